// File: rtl/prog_counter_pkg.sv
// Shared encodings for the programmable counter: mode selection and one-shot FSM states.
package prog_counter_pkg;

    // Counting modes; 2'b11 is reserved and behaves as wrap.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    // One-shot sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/prog_counter_tick_gen.sv
// Prescaler: emits one tick every PRESCALE enabled cycles; PRESCALE=1 passes en straight through.
module tick_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Prescale counter: restarts on reset, external clear or a tick, advances while enabled.
    always_ff @(posedge clk) begin
        if (reset || clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + PW'(1);
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Parametrised up/down counter with wrap/saturate/one-shot modes, load, prescale and terminal-count pulse.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    state_t           state;
    state_t           state_nx;
    logic             oneshot;
    logic             wrap_mode;
    logic             permitted;
    logic             start_go;
    logic             tick;
    logic             step;
    logic             at_bound;
    logic             bound;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_nx;

    assign oneshot   = (mode == MODE_ONESHOT);
    assign wrap_mode = (mode == MODE_WRAP) || (mode == MODE_RSVD);

    // In one-shot mode counting is only allowed while the sequencer runs.
    assign permitted = !oneshot || (state == ST_RUN);

    // A start is honoured only in one-shot mode and only when not already running.
    assign start_go  = oneshot && start && (state != ST_RUN);

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .en   (en && permitted),
        .clr  (load || start_go),
        .tick (tick)
    );

    // Load has priority over a step in the same cycle.
    assign step     = tick && !load;
    assign at_bound = up_dn ? (count == MAXV) : (count == '0);
    assign bound    = step && at_bound;

    assign load_clamped = (load_val > MAXV) ? MAXV : load_val;

    // Next count value: load, normal step, or boundary behaviour selected by mode.
    always_comb begin
        count_nx = count;
        if (load) begin
            count_nx = load_clamped;
        end else if (step) begin
            if (!at_bound) begin
                count_nx = up_dn ? (count + WIDTH'(1)) : (count - WIDTH'(1));
            end else if (wrap_mode) begin
                count_nx = up_dn ? '0 : MAXV;
            end
        end
    end

    // Count and terminal-count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            count <= count_nx;
            tc    <= bound;
        end
    end

    // One-shot FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // One-shot FSM next-state logic; leaving one-shot mode always returns to IDLE.
    always_comb begin
        state_nx = state;
        if (!oneshot) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start_go) state_nx = ST_RUN;
                ST_RUN:           if (bound)    state_nx = ST_DONE;
                default:                        state_nx = ST_IDLE;
            endcase
        end
    end

    // One-shot FSM outputs; busy decodes the registered state directly.
    always_comb begin
        busy = (state == ST_RUN);
    end

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: two instances (PRESCALE 1 and 3) against a behavioural model.
module tb_prog_counter;

    localparam int W    = 4;
    localparam int MAXV = 9;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         up_dn = 1'b1;
    logic [1:0]   mode = 2'b00;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;

    logic [W-1:0] count1, count3;
    logic         tc1, tc3, busy1, busy3;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    prog_counter #(.WIDTH(W), .MAX_VAL(MAXV), .PRESCALE(1)) u_p1 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
        .load_val(load_val), .start(start), .count(count1), .tc(tc1), .busy(busy1)
    );

    prog_counter #(.WIDTH(W), .MAX_VAL(MAXV), .PRESCALE(3)) u_p3 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
        .load_val(load_val), .start(start), .count(count3), .tc(tc3), .busy(busy3)
    );

    // Behavioural model: count value, pulse, "running" flag and enabled-cycle tally.
    typedef struct {
        int cnt;
        bit tc;
        bit run;
        int pre;
    } mdl_t;

    mdl_t m1;
    mdl_t m3;

    function automatic mdl_t mdl_next(mdl_t s, int p, bit rst, bit e, bit up, bit [1:0] md,
                                      bit ld, int lv, bit st);
        mdl_t n;
        bit   os, go, perm, stp, bnd;
        n = s;
        if (rst) begin
            n.cnt = 0; n.tc = 0; n.run = 0; n.pre = 0;
            return n;
        end
        os   = (md == 2'b10);
        go   = os && st && !s.run;
        perm = !os || s.run;
        stp  = e && !ld && perm && (s.pre == p - 1);
        bnd  = stp && (up ? (s.cnt == MAXV) : (s.cnt == 0));
        if (ld || go || stp)  n.pre = 0;
        else if (e && perm)   n.pre = s.pre + 1;
        if (ld) begin
            n.cnt = (lv > MAXV) ? MAXV : lv;
        end else if (stp) begin
            if (!bnd)                           n.cnt = up ? s.cnt + 1 : s.cnt - 1;
            else if (md == 2'b00 || md == 2'b11) n.cnt = up ? 0 : MAXV;
        end
        n.tc = bnd;
        if (!os)      n.run = 0;
        else if (go)  n.run = 1;
        else if (bnd) n.run = 0;
        return n;
    endfunction

    always @(posedge clk) begin
        m1 <= mdl_next(m1, 1, reset, en, up_dn, mode, load, int'(load_val), start);
        m3 <= mdl_next(m3, 3, reset, en, up_dn, mode, load, int'(load_val), start);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model comparison on every falling edge once reset has taken effect.
    always @(negedge clk) begin
        if (chk_on) begin
            check("p1.count", int'(count1), m1.cnt);
            check("p1.tc",    int'(tc1),    int'(m1.tc));
            check("p1.busy",  int'(busy1),  int'(m1.run));
            check("p3.count", int'(count3), m3.cnt);
            check("p3.tc",    int'(tc3),    int'(m3.tc));
            check("p3.busy",  int'(busy3),  int'(m3.run));
        end
    end

    initial begin
        // Reset values.
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        check("rst.count", int'(count1), 0);
        check("rst.tc",    int'(tc1),    0);
        check("rst.busy",  int'(busy1),  0);

        // Wrap up 0..9,0,1 with tc only on the 9->0 step.
        reset = 1'b0; mode = 2'b00; up_dn = 1'b1; en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check("wrap_up.count", int'(count1), (i + 1) % 10);
            check("wrap_up.tc",    int'(tc1),    ((i + 1) % 10 == 0) ? 1 : 0);
        end

        // Wrap down from 0 to 9.
        load = 1'b1; load_val = 4'd0;
        @(negedge clk);
        check("wrap_dn.load", int'(count1), 0);
        load = 1'b0; up_dn = 1'b0;
        @(negedge clk);
        check("wrap_dn.count", int'(count1), 9);
        check("wrap_dn.tc",    int'(tc1),    1);

        // Saturate up from 8: 8, 9, 9, 9 with tc on the hold steps.
        mode = 2'b01; up_dn = 1'b1; load = 1'b1; load_val = 4'd8;
        @(negedge clk);
        check("sat.load", int'(count1), 8);
        load = 1'b0;
        @(negedge clk);
        check("sat.c9",  int'(count1), 9);
        check("sat.tc0", int'(tc1),    0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("sat.hold", int'(count1), 9);
            check("sat.tc",   int'(tc1),    1);
        end

        // Load clamp and priority over step.
        mode = 2'b00; load = 1'b1; load_val = 4'd15;
        @(negedge clk);
        check("clamp.count", int'(count1), 9);
        check("clamp.tc",    int'(tc1),    0);
        load_val = 4'd3;
        @(negedge clk);
        check("load3.count", int'(count1), 3);
        load = 1'b0;

        // Prescale 3 with a 2-cycle enable gap.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; en = 1'b1; up_dn = 1'b1; mode = 2'b00;
        @(negedge clk); check("pre.e1", int'(count3), 0);
        @(negedge clk); check("pre.e2", int'(count3), 0);
        @(negedge clk); check("pre.e3", int'(count3), 1);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk); check("pre.gap1", int'(count3), 1);
        @(negedge clk); check("pre.gap2", int'(count3), 1);
        en = 1'b1;
        @(negedge clk); check("pre.res1", int'(count3), 1);
        @(negedge clk); check("pre.res2", int'(count3), 2);

        // One-shot: simultaneous load+start, run to 9, boundary step ends the run.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mode = 2'b10; up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd7; start = 1'b1;
        @(negedge clk);
        check("os.c7",   int'(count1), 7);
        check("os.busy", int'(busy1),  1);
        load = 1'b0; start = 1'b0;
        @(negedge clk); check("os.c8", int'(count1), 8);
        @(negedge clk); check("os.c9", int'(count1), 9);
        check("os.busy9", int'(busy1), 1);
        @(negedge clk);
        check("os.end.count", int'(count1), 9);
        check("os.end.tc",    int'(tc1),    1);
        check("os.end.busy",  int'(busy1),  0);
        @(negedge clk);
        check("os.idle.tc",   int'(tc1),    0);
        start = 1'b1;
        @(negedge clk);
        check("os.restart.busy", int'(busy1), 1);
        start = 1'b0;
        @(negedge clk);
        check("os.again.tc",   int'(tc1),   1);
        check("os.again.busy", int'(busy1), 0);

        // Reset mid-run with the prescaler mid-period.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; load = 1'b1; load_val = 4'd2; start = 1'b1;
        @(negedge clk);
        check("mid.busy", int'(busy3), 1);
        load = 1'b0; start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid.count", int'(count3), 0);
        check("mid.busy0", int'(busy3), 0);
        check("mid.tc0",   int'(tc3),   0);
        reset = 1'b0; mode = 2'b00;
        @(negedge clk); check("mid.p1", int'(count3), 0);
        @(negedge clk); check("mid.p2", int'(count3), 0);
        @(negedge clk); check("mid.p3", int'(count3), 1);

        // Randomised traffic across all modes, checked by the model process.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 8) up_dn = ~up_dn;
            if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
            load     = ($urandom_range(0, 99) < 4);
            load_val = W'($urandom_range(0, 15));
            start    = ($urandom_range(0, 99) < 10);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
